move_piece_param: RTL and testbench

Parametrised, single-clock successor to the Tetris piece-move FSM. Takes a COLS×ROWS occupancy board and a falling piece (type, anchor location, rotation), applies one player action (rotate/left/right) with wall and collision checking, then attempts a one-row drop. When the drop fails, it locks the piece into the board and optionally clears full rows. Sits between the game controller and the board register; one start→done transaction per game tick.

---
 rtl/tetris_pkg.sv | 38 +++
 rtl/move_piece_param_if.sv | 39 +++
 rtl/piece_mask_fit.sv | 48 ++++
 rtl/move_piece_param.sv | 182 ++++++++++++++++++
 tb/tb_move_piece_param.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris piece-move datapath: FSM states, piece
// codes and the 2x2 shape-mask ROM.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DROP,
        ST_CLEAR,
        ST_DONE
    } state_t;

    localparam logic [1:0] PIECE_SINGLE = 2'd0;
    localparam logic [1:0] PIECE_DOMINO = 2'd1;
    localparam logic [1:0] PIECE_L      = 2'd2;
    localparam logic [1:0] PIECE_SQUARE = 2'd3;

    // Mask bit i covers cell (row + i/2, col + i%2) of the anchor's 2x2 box.
    function automatic logic [3:0] shape_mask(input logic [1:0] piece_type,
                                              input logic [1:0] rot);
        logic [3:0] mask;
        case (piece_type)
            PIECE_SINGLE: mask = 4'b0001;
            PIECE_DOMINO: mask = rot[0] ? 4'b0101 : 4'b0011;
            PIECE_L: begin
                case (rot)
                    2'd0:    mask = 4'b0111;
                    2'd1:    mask = 4'b1011;
                    2'd2:    mask = 4'b1110;
                    default: mask = 4'b1101;
                endcase
            end
            default:      mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/move_piece_param_if.sv
// Controller <-> piece-move bundle: piece/board inputs, player actions,
// start/done handshake and the resulting piece/board state.
interface move_piece_param_if #(
    parameter int COLS  = 4,
    parameter int ROWS  = 8,
    parameter int LOC_W = $clog2(COLS*ROWS)
);
    localparam int LC_W = $clog2(ROWS+1);

    logic                   start;
    logic [COLS*ROWS-1:0]   curr_board_state;
    logic [1:0]             curr_piece_type;
    logic [LOC_W-1:0]       curr_piece_location;
    logic [1:0]             curr_piece_rotation;
    logic                   left;
    logic                   right;
    logic                   rotate;
    logic [LOC_W-1:0]       new_location;
    logic [1:0]             new_rotation;
    logic [COLS*ROWS-1:0]   new_board_state;
    logic                   done;
    logic                   touched;
    logic                   busy;
    logic [LC_W-1:0]        lines_cleared;

    modport master (
        output start, curr_board_state, curr_piece_type, curr_piece_location,
               curr_piece_rotation, left, right, rotate,
        input  new_location, new_rotation, new_board_state, done, touched,
               busy, lines_cleared
    );

    modport slave (
        input  start, curr_board_state, curr_piece_type, curr_piece_location,
               curr_piece_rotation, left, right, rotate,
        output new_location, new_rotation, new_board_state, done, touched,
               busy, lines_cleared
    );
endinterface

// File: rtl/piece_mask_fit.sv
// Combinational placement check: expands a piece's 2x2 mask at an anchor into
// board cells and reports whether every cell is on the board and free.
module piece_mask_fit
    import tetris_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int ROWS  = 8,
    parameter int LOC_W = $clog2(COLS*ROWS)
) (
    input  logic [COLS*ROWS-1:0] board,
    input  logic [1:0]           piece_type,
    input  logic [1:0]           rotation,
    input  logic [LOC_W-1:0]     location,
    output logic                 fits,
    output logic [COLS*ROWS-1:0] cells
);
    logic [3:0]       mask;
    logic [LOC_W-1:0] idx;
    int               row;
    int               col;
    int               r;
    int               c;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path infers a latch.
        mask  = shape_mask(piece_type, rotation);
        row   = int'(location) / COLS;
        col   = int'(location) % COLS;
        fits  = 1'b1;
        cells = '0;
        idx   = '0;
        r     = 0;
        c     = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                r = row + i / 2;
                c = col + i % 2;
                if (r >= ROWS || c >= COLS) begin
                    fits = 1'b0;
                end else begin
                    idx        = LOC_W'(r * COLS + c);
                    cells[idx] = 1'b1;
                    if (board[idx]) fits = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/move_piece_param.sv
// Tetris piece-move FSM: one action, one-row drop, lock and optional row
// clearing per start->done transaction. Row clearing is built when LINE_CLEAR_EN is defined.
module move_piece_param
    import tetris_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int ROWS  = 8,
    parameter int LOC_W = $clog2(COLS*ROWS)
) (
    input  logic                clka,
    input  logic                reset,
    move_piece_param_if.slave   bus
);
    localparam int               N      = COLS * ROWS;
    localparam int               LC_W   = $clog2(ROWS+1);
    localparam logic [LOC_W-1:0] COLS_L = LOC_W'(COLS);

    state_t           state;
    logic [1:0]       type_q;
    logic             rotate_q, left_q, right_q;

    logic [N-1:0]     fit_board, fit_cells;
    logic [1:0]       fit_type, fit_rot;
    logic [LOC_W-1:0] fit_loc;
    logic             fit_ok;

    logic [LOC_W-1:0] cur_col, move_loc;
    logic [1:0]       move_rot;
    logic             move_try, drop_ok;

    assign cur_col = bus.new_location % COLS_L;

    // One checker shared over time: raw inputs in IDLE, the action candidate
    // in MOVE, and the current placement otherwise (DROP derives the drop from it).
    always_comb begin
        fit_board = bus.new_board_state;
        fit_type  = type_q;
        fit_rot   = bus.new_rotation;
        fit_loc   = bus.new_location;
        if (state == ST_IDLE) begin
            fit_board = bus.curr_board_state;
            fit_type  = bus.curr_piece_type;
            fit_rot   = bus.curr_piece_rotation;
            fit_loc   = bus.curr_piece_location;
        end else if (state == ST_MOVE) begin
            fit_rot = move_rot;
            fit_loc = move_loc;
        end
    end

    piece_mask_fit #(.COLS(COLS), .ROWS(ROWS), .LOC_W(LOC_W)) u_fit (
        .board      (fit_board),
        .piece_type (fit_type),
        .rotation   (fit_rot),
        .location   (fit_loc),
        .fits       (fit_ok),
        .cells      (fit_cells)
    );

    always_comb begin
        move_rot = bus.new_rotation;
        move_loc = bus.new_location;
        move_try = 1'b0;
        if (rotate_q) begin
            move_rot = bus.new_rotation + 2'd1;
            move_try = 1'b1;
        end else if (left_q) begin
            move_loc = bus.new_location - LOC_W'(1);
            move_try = (cur_col != '0);
        end else if (right_q) begin
            move_loc = bus.new_location + LOC_W'(1);
            move_try = (cur_col != COLS_L - LOC_W'(1));
        end
    end

    // Drop fits when no cell sits on the bottom row and the cells shifted one row down are free.
    assign drop_ok = (fit_cells[N-1 -: COLS] == '0) &&
                     (((fit_cells << COLS) & bus.new_board_state) == '0);

`ifdef LINE_CLEAR_EN
    logic         any_full;
    int           full_row;
    logic [N-1:0] cleared_board;

    always_comb begin
        any_full = 1'b0;
        full_row = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (&bus.new_board_state[r*COLS +: COLS]) begin
                any_full = 1'b1;
                full_row = r;
            end
        end
        cleared_board = bus.new_board_state;
        for (int r = 1; r < ROWS; r++) begin
            if (r <= full_row) cleared_board[r*COLS +: COLS] = bus.new_board_state[(r-1)*COLS +: COLS];
        end
        cleared_board[COLS-1:0] = '0;
    end
`else
    assign bus.lines_cleared = '0;
`endif

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            type_q               <= '0;
            rotate_q             <= 1'b0;
            left_q               <= 1'b0;
            right_q              <= 1'b0;
            bus.new_location     <= '0;
            bus.new_rotation     <= '0;
            bus.new_board_state  <= '0;
            bus.done             <= 1'b0;
            bus.touched          <= 1'b0;
            bus.busy             <= 1'b0;
`ifdef LINE_CLEAR_EN
            bus.lines_cleared    <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        type_q              <= bus.curr_piece_type;
                        rotate_q            <= bus.rotate;
                        left_q              <= bus.left;
                        right_q             <= bus.right;
                        bus.new_location    <= bus.curr_piece_location;
                        bus.new_rotation    <= bus.curr_piece_rotation;
                        bus.new_board_state <= bus.curr_board_state;
                        bus.busy            <= 1'b1;
                        bus.touched         <= !fit_ok;
`ifdef LINE_CLEAR_EN
                        bus.lines_cleared   <= '0;
`endif
                        state               <= fit_ok ? ST_MOVE : ST_DONE;
                    end
                end
                ST_MOVE: begin
                    if (move_try && fit_ok) begin
                        bus.new_location <= move_loc;
                        bus.new_rotation <= move_rot;
                    end
                    state <= ST_DROP;
                end
                ST_DROP: begin
                    if (drop_ok) begin
                        bus.new_location <= bus.new_location + COLS_L;
                        bus.touched      <= 1'b0;
                        state            <= ST_DONE;
                    end else begin
                        bus.new_board_state <= bus.new_board_state | fit_cells;
                        bus.touched         <= 1'b1;
`ifdef LINE_CLEAR_EN
                        state               <= ST_CLEAR;
`else
                        state               <= ST_DONE;
`endif
                    end
                end
`ifdef LINE_CLEAR_EN
                ST_CLEAR: begin
                    if (any_full) begin
                        bus.new_board_state <= cleared_board;
                        bus.lines_cleared   <= bus.lines_cleared + LC_W'(1);
                    end else begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_piece_param.sv
// Scoreboard bench for move_piece_param (COLS=4, ROWS=8): directed cases plus
// randomized transactions checked against a row/column reference model.
`timescale 1ns/1ps
module tb_move_piece_param;
    localparam int COLS  = 4;
    localparam int ROWS  = 8;
    localparam int N     = COLS * ROWS;
    localparam int LOC_W = 5;
    localparam int LC_W  = 4;

    logic clka = 1'b0;
    logic reset;
    always #5 clka = ~clka;

    move_piece_param_if #(.COLS(COLS), .ROWS(ROWS)) bus();

    move_piece_param #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clka  (clka),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [LOC_W-1:0] loc;
        logic [1:0]       rot;
        logic [N-1:0]     board;
        logic             touched;
        logic [LC_W-1:0]  lines;
        int               lat;
        int               done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Shape table: shape_tbl[type][rot], bit i = cell (row + i/2, col + i%2).
    logic [3:0] shape_tbl [4][4] = '{
        '{4'b0001, 4'b0001, 4'b0001, 4'b0001},
        '{4'b0011, 4'b0101, 4'b0011, 4'b0101},
        '{4'b0111, 4'b1011, 4'b1110, 4'b1101},
        '{4'b1111, 4'b1111, 4'b1111, 4'b1111}
    };

    always @(posedge clka) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit fits(input logic [N-1:0] b, input int t, input int rot,
                                input int row, input int col);
        int rr, cc;
        for (int i = 0; i < 4; i++) begin
            if (shape_tbl[t][rot][i]) begin
                rr = row + i / 2;
                cc = col + i % 2;
                if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) return 1'b0;
                if (b[rr*COLS + cc]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic exp_t model(input logic [N-1:0] b, input int t, input int rot,
                                   input int loc, input bit rt, input bit lf, input bit rg);
        exp_t e;
        int row, col, n, dst;
        logic [COLS-1:0] rv;
        logic [N-1:0] nb;
        row = loc / COLS;
        col = loc % COLS;
        e.lines = '0;
        e.done_cyc = 0;
        n = 0;
        dst = ROWS - 1;
        nb = '0;
        rv = '0;
        // Unplaceable piece: nothing moves or locks, DONE follows IDLE directly.
        if (!fits(b, t, rot, row, col)) begin
            e.loc = LOC_W'(loc); e.rot = 2'(rot); e.board = b; e.touched = 1'b1; e.lat = 1;
            return e;
        end
        if (rt) begin
            if (fits(b, t, (rot + 1) % 4, row, col)) rot = (rot + 1) % 4;
        end else if (lf) begin
            if (fits(b, t, rot, row, col - 1)) col = col - 1;
        end else if (rg) begin
            if (fits(b, t, rot, row, col + 1)) col = col + 1;
        end
        e.lat = 3;
        if (fits(b, t, rot, row + 1, col)) begin
            row = row + 1;
            e.touched = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (shape_tbl[t][rot][i]) b[(row + i/2)*COLS + col + i%2] = 1'b1;
            e.touched = 1'b1;
`ifdef LINE_CLEAR_EN
            // Net effect of clearing: full rows vanish, the rest settle at the bottom.
            for (int r = ROWS - 1; r >= 0; r--) begin
                rv = b[r*COLS +: COLS];
                if (&rv) n++;
                else begin
                    nb[dst*COLS +: COLS] = rv;
                    dst--;
                end
            end
            b = nb;
            e.lines = LC_W'(n);
            e.lat = 3 + n + 1;
`endif
        end
        e.board = b;
        e.loc = LOC_W'(row*COLS + col);
        e.rot = 2'(rot);
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] b, input int t, input int rot, input int loc,
                         input bit rt, input bit lf, input bit rg);
        bus.curr_board_state    = b;
        bus.curr_piece_type     = 2'(t);
        bus.curr_piece_rotation = 2'(rot);
        bus.curr_piece_location = LOC_W'(loc);
        bus.rotate              = rt;
        bus.left                = lf;
        bus.right               = rg;
        bus.start               = 1'b1;
    endtask

    task automatic wait_idle();
        bit emptied;
        emptied = 1'b0;
        for (int i = 0; i < 40 && !emptied; i++) begin
            @(posedge clka); #2;
            if (sb.size() == 0) emptied = 1'b1;
        end
        if (!emptied) begin
            check("txn_timeout_pending", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    task automatic run_txn(input logic [N-1:0] b, input int t, input int rot, input int loc,
                           input bit rt, input bit lf, input bit rg);
        exp_t e;
        e = model(b, t, rot, loc, rt, lf, rg);
        drive(b, t, rot, loc, rt, lf, rg);
        @(posedge clka); #1;
        bus.start = 1'b0;
        e.done_cyc = cyc + e.lat;
        sb.push_back(e);
        check("busy_after_start", 64'(bus.busy), 64'(1));
        wait_idle();
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clka);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(bus.done), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("new_location",    64'(bus.new_location),    64'(mon_e.loc));
                    check("new_rotation",    64'(bus.new_rotation),    64'(mon_e.rot));
                    check("new_board_state", 64'(bus.new_board_state), 64'(mon_e.board));
                    check("touched",         64'(bus.touched),         64'(mon_e.touched));
                    check("lines_cleared",   64'(bus.lines_cleared),   64'(mon_e.lines));
                    check("done_cycle",      64'(cyc),                 64'(mon_e.done_cyc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] rb;
    exp_t         be;

    initial begin
        reset = 1'b1;
        drive('0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        check("rst_new_location",    64'(bus.new_location),    64'(0));
        check("rst_new_rotation",    64'(bus.new_rotation),    64'(0));
        check("rst_new_board_state", 64'(bus.new_board_state), 64'(0));
        check("rst_done",            64'(bus.done),            64'(0));
        check("rst_touched",         64'(bus.touched),         64'(0));
        check("rst_busy",            64'(bus.busy),            64'(0));
        check("rst_lines_cleared",   64'(bus.lines_cleared),   64'(0));
        reset = 1'b0;
        @(posedge clka); #2;

        run_txn(32'h0000_0000, 0, 0, 2,  1'b0, 1'b0, 1'b0);
        run_txn(32'h0000_0000, 0, 0, 4,  1'b0, 1'b1, 1'b0);
        run_txn(32'h0000_0000, 3, 0, 24, 1'b0, 1'b0, 1'b0);
        run_txn(32'hC000_0000, 3, 0, 24, 1'b0, 1'b0, 1'b0);
        run_txn(32'h0000_0020, 2, 0, 0,  1'b1, 1'b1, 1'b0);
        run_txn(32'h0000_0000, 1, 1, 3,  1'b0, 1'b0, 1'b1);
        run_txn(32'h0000_0001, 0, 0, 0,  1'b0, 1'b0, 1'b0);

        // Reset while the FSM sits in DROP: outputs clear at once, no done follows.
        drive(32'h0000_0000, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        @(posedge clka); #1;
        bus.start = 1'b0;
        @(posedge clka); #1;
        reset = 1'b1;
        #1;
        check("midrst_new_location", 64'(bus.new_location), 64'(0));
        check("midrst_busy",         64'(bus.busy),         64'(0));
        check("midrst_board",        64'(bus.new_board_state), 64'(0));
        check("midrst_done",         64'(bus.done),         64'(0));
        @(posedge clka); #1;
        reset = 1'b0;
        repeat (8) @(posedge clka);
        #2;

        // A start pulse while busy must not produce a second done.
        be = model(32'h0000_0000, 2, 1, 9, 1'b0, 1'b0, 1'b1);
        drive(32'h0000_0000, 2, 1, 9, 1'b0, 1'b0, 1'b1);
        @(posedge clka); #1;
        bus.start = 1'b0;
        be.done_cyc = cyc + be.lat;
        sb.push_back(be);
        @(posedge clka); #1;
        bus.start = 1'b1;
        check("busy_mid_txn", 64'(bus.busy), 64'(1));
        @(posedge clka); #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (6) @(posedge clka);
        #2;

        for (int i = 0; i < 300; i++) begin
            rb = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) begin
                rb[N-1 -: COLS] = '1;
                rb[N - COLS + int'($urandom_range(0, COLS - 1))] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) rb[N-COLS-1 -: COLS] = COLS'($urandom | 32'h3);
            run_txn(rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clka);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
